// File: rtl/free_list_nway_pkg.sv
// Shared definitions for the N-wide free list: branch outcome encodings, tag type
// and default register-file sizes.
`ifndef BR_STATE_W
`define BR_STATE_W 2
`endif

package free_list_nway_pkg;

  localparam int PREG_NUM = 64;
  localparam int AREG_NUM = 32;
  localparam int PW       = $clog2(PREG_NUM);

  typedef logic [PW-1:0] preg_t;

  typedef enum logic [`BR_STATE_W-1:0] {
    NO_BRANCH     = `BR_STATE_W'(0),
    PREDICT_RIGHT = `BR_STATE_W'(1),
    PREDICT_WRONG = `BR_STATE_W'(2)
  } br_state_t;

endpackage

// File: rtl/fl_ptr_add.sv
// Wrap-aware pointer adder for a DEPTH-entry ring; DEPTH need not be a power of two.
// With WB=1 the pointer carries a wrap bit that toggles when the index passes DEPTH-1.
module fl_ptr_add #(
  parameter int DEPTH = 32,
  parameter int IW    = 2,
  parameter int WB    = 1,
  parameter int IXW   = $clog2(DEPTH)
) (
  input  logic [IXW+WB-1:0] ptr,
  input  logic [IW-1:0]     inc,
  output logic [IXW+WB-1:0] sum
);

  localparam logic [IXW:0]   DEP    = DEPTH[IXW:0];
  localparam logic [IXW-1:0] DEP_LO = DEPTH[IXW-1:0];

  logic [IXW:0]   inc_ext;
  logic [IXW:0]   raw;
  logic [IXW-1:0] wrapped;
  logic           carry;

  always_comb begin
    inc_ext          = '0;
    inc_ext[IW-1:0]  = inc;
    raw              = {1'b0, ptr[IXW-1:0]} + inc_ext;
    // The true wrapped value is below DEPTH, so the low bits of the difference suffice.
    wrapped          = raw[IXW-1:0] - DEP_LO;
    carry            = (raw >= DEP);
  end

  if (WB != 0) begin : g_wrap
    always_comb sum = {ptr[IXW] ^ carry, carry ? wrapped : raw[IXW-1:0]};
  end else begin : g_nowrap
    always_comb sum = carry ? wrapped : raw[IXW-1:0];
  end

endmodule

// File: rtl/free_list_nway.sv
// N-wide circular free list of physical register tags with single-cycle head restore.
// Define FL_DUP_CHECK_EN to add an in-list scoreboard that flags double frees.
module free_list_nway #(
  parameter int PREG_NUM = free_list_nway_pkg::PREG_NUM,
  parameter int AREG_NUM = free_list_nway_pkg::AREG_NUM,
  parameter int DISP_W   = 2,
  parameter int RET_W    = 2,
  localparam int DEPTH   = PREG_NUM - AREG_NUM,
  localparam int PW      = $clog2(PREG_NUM),
  localparam int QW      = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DISP_W-1:0]       dispatch_en_i,
  input  logic [RET_W-1:0]        retire_en_i,
  input  logic [RET_W*PW-1:0]     retire_preg_i,
  input  logic [`BR_STATE_W-1:0]  branch_state_i,
  input  logic [QW-1:0]           rc_head_i,
  output logic [DISP_W-1:0]       free_preg_vld_o,
  output logic [DISP_W*PW-1:0]    free_preg_o,
  output logic [QW-1:0]           free_preg_cur_head_o,
  output logic [QW-1:0]           free_cnt_o,
  output logic                    fl_err_o
);

  import free_list_nway_pkg::*;

  localparam int IXW  = QW - 1;
  localparam int MAXW = (DISP_W > RET_W) ? DISP_W : RET_W;
  localparam int IW   = $clog2(MAXW + 1);
  localparam logic [QW-1:0] DEP_Q = DEPTH[QW-1:0];

  logic [QW-1:0]  head, tail, head_nxt, tail_nxt, cnt, space;
  logic [PW-1:0]  entry    [DEPTH];
  logic [IXW-1:0] rd_idx   [DISP_W];
  logic [IXW-1:0] wr_idx   [RET_W];
  logic [PW-1:0]  lane_tag [DISP_W];
  logic [PW-1:0]  ret_tag  [RET_W];
  logic [IW-1:0]  slot     [RET_W];
  logic [IW-1:0]  plen, pops, pushes;
  logic [RET_W-1:0] wr_en;
  logic           run, nonprefix, drop, mispredict, dup_err, err;

  function automatic logic [QW-1:0] ptr_diff(input logic [QW-1:0] a, input logic [QW-1:0] b);
    logic [QW-1:0] d;
    d = {1'b0, a[IXW-1:0]} - {1'b0, b[IXW-1:0]};
    if (a[IXW] != b[IXW]) d = d + DEP_Q;
    return d;
  endfunction

  assign cnt        = ptr_diff(tail, head);
  assign space      = DEP_Q - cnt;
  assign mispredict = (branch_state_i == PREDICT_WRONG);

  for (genvar i = 0; i < DISP_W; i++) begin : g_rd
    fl_ptr_add #(.DEPTH(DEPTH), .IW(IW), .WB(0)) u_rd (
      .ptr(head[IXW-1:0]), .inc(IW'(i)), .sum(rd_idx[i])
    );
    assign lane_tag[i]             = entry[rd_idx[i]];
    assign free_preg_o[i*PW +: PW] = lane_tag[i];
    assign free_preg_vld_o[i]      = cnt > QW'(i);
  end

  for (genvar j = 0; j < RET_W; j++) begin : g_wr
    assign ret_tag[j] = retire_preg_i[j*PW +: PW];
    fl_ptr_add #(.DEPTH(DEPTH), .IW(IW), .WB(0)) u_wr (
      .ptr(tail[IXW-1:0]), .inc(slot[j]), .sum(wr_idx[j])
    );
  end

  fl_ptr_add #(.DEPTH(DEPTH), .IW(IW), .WB(1)) u_head (.ptr(head), .inc(pops), .sum(head_nxt));
  fl_ptr_add #(.DEPTH(DEPTH), .IW(IW), .WB(1)) u_tail (.ptr(tail), .inc(pushes), .sum(tail_nxt));

  // Only the leading run of requests is honoured, clipped to what is actually available.
  always_comb begin
    plen      = '0;
    run       = 1'b1;
    nonprefix = 1'b0;
    for (int unsigned i = 0; i < DISP_W; i++) begin
      if (!dispatch_en_i[i]) run = 1'b0;
      else if (run)          plen = plen + IW'(1);
      else                   nonprefix = 1'b1;
    end
    pops = (QW'(plen) > cnt) ? IW'(cnt) : plen;
  end

  // Enabled retire lanes are packed in lane order; space uses the pre-pop count.
  always_comb begin
    pushes = '0;
    drop   = 1'b0;
    wr_en  = '0;
    for (int unsigned j = 0; j < RET_W; j++) begin
      slot[j] = pushes;
      if (retire_en_i[j]) begin
        if (QW'(pushes) < space) begin
          wr_en[j] = 1'b1;
          pushes   = pushes + IW'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= {1'b1, {IXW{1'b0}}};
      err  <= 1'b0;
      for (int unsigned k = 0; k < DEPTH; k++) entry[k] <= PW'(AREG_NUM + k);
    end else begin
      head <= mispredict ? rc_head_i : head_nxt;
      tail <= tail_nxt;
      for (int unsigned j = 0; j < RET_W; j++) begin
        if (wr_en[j]) entry[wr_idx[j]] <= ret_tag[j];
      end
      if (nonprefix || (QW'(plen) > cnt) || drop || dup_err) err <= 1'b1;
    end
  end

`ifdef FL_DUP_CHECK_EN
  logic [PREG_NUM-1:0] in_list, in_list_nxt;
  logic [QW-1:0]       dist, ridx;
  logic                dup_hit;

  always_comb begin
    in_list_nxt = in_list;
    dup_hit     = 1'b0;
    ridx        = '0;
    dist        = ptr_diff(head, rc_head_i);
    if (mispredict) begin
      // Tags between the checkpoint and the current head return to the list.
      for (int unsigned k = 0; k < DEPTH; k++) begin
        ridx = {1'b0, rc_head_i[IXW-1:0]} + QW'(k);
        if (ridx >= DEP_Q) ridx = ridx - DEP_Q;
        if (QW'(k) < dist) in_list_nxt[entry[ridx[IXW-1:0]]] = 1'b1;
      end
    end else begin
      for (int unsigned i = 0; i < DISP_W; i++) begin
        if (IW'(i) < pops) in_list_nxt[lane_tag[i]] = 1'b0;
      end
    end
    for (int unsigned j = 0; j < RET_W; j++) begin
      if (retire_en_i[j]) begin
        if (in_list[ret_tag[j]]) dup_hit = 1'b1;
        for (int unsigned m = 0; m < j; m++) begin
          if (retire_en_i[m] && (ret_tag[m] == ret_tag[j])) dup_hit = 1'b1;
        end
        if (wr_en[j]) in_list_nxt[ret_tag[j]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) in_list <= {{DEPTH{1'b1}}, {AREG_NUM{1'b0}}};
    else     in_list <= in_list_nxt;
  end

  assign dup_err = dup_hit;
`else
  assign dup_err = 1'b0;
`endif

  assign free_preg_cur_head_o = head;
  assign free_cnt_o           = cnt;
  assign fl_err_o             = err;

endmodule

// File: tb/tb_free_list_nway.sv
// Directed bench for free_list_nway: an abstract ring model (absolute head/tail counts)
// is checked every cycle, with hand-computed literal checks at key points.
module tb_free_list_nway;
  import free_list_nway_pkg::*;

  localparam int DEPTH  = 32;
  localparam int DISP_W = 2;
  localparam int RET_W  = 2;
  localparam int PW     = 6;
  localparam int QW     = 6;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [DISP_W-1:0]      dispatch_en_i;
  logic [RET_W-1:0]       retire_en_i;
  logic [RET_W*PW-1:0]    retire_preg_i;
  logic [`BR_STATE_W-1:0] branch_state_i;
  logic [QW-1:0]          rc_head_i;
  logic [DISP_W-1:0]      free_preg_vld_o;
  logic [DISP_W*PW-1:0]   free_preg_o;
  logic [QW-1:0]          free_preg_cur_head_o;
  logic [QW-1:0]          free_cnt_o;
  logic                   fl_err_o;

  free_list_nway #(.PREG_NUM(64), .AREG_NUM(32), .DISP_W(DISP_W), .RET_W(RET_W)) dut (
    .clk(clk), .rst(rst),
    .dispatch_en_i(dispatch_en_i), .retire_en_i(retire_en_i), .retire_preg_i(retire_preg_i),
    .branch_state_i(branch_state_i), .rc_head_i(rc_head_i),
    .free_preg_vld_o(free_preg_vld_o), .free_preg_o(free_preg_o),
    .free_preg_cur_head_o(free_preg_cur_head_o), .free_cnt_o(free_cnt_o), .fl_err_o(fl_err_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int mem [DEPTH];
  int mhead, mtail;
  bit merr;
  bit model_ok = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [QW-1:0] enc(input int a);
    return QW'((a % DEPTH) + ((a / DEPTH) % 2) * (1 << (QW - 1)));
  endfunction

  function automatic int lane_tag(input int i);
    logic [DISP_W*PW-1:0] v;
    v = free_preg_o >> (i * PW);
    return int'(v[PW-1:0]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) mem[k] = 32 + k;
    mhead    = 0;
    mtail    = DEPTH;
    merr     = 1'b0;
    model_ok = 1'b1;
  endtask

  task automatic model_step(input int rc_abs);
    int  c, plen, pops, space, tag;
    bit  run, np;
    c = mtail - mhead;
    plen = 0; run = 1'b1; np = 1'b0;
    for (int i = 0; i < DISP_W; i++) begin
      if (!dispatch_en_i[i]) run = 1'b0;
      else if (run)          plen++;
      else                   np = 1'b1;
    end
    pops = (plen < c) ? plen : c;
    if (np || plen > c) merr = 1'b1;
`ifdef FL_DUP_CHECK_EN
    for (int j = 0; j < RET_W; j++) begin
      if (retire_en_i[j]) begin
        tag = int'(retire_preg_i[j*PW +: PW]);
        for (int i = 0; i < c; i++) if (mem[(mhead + i) % DEPTH] == tag) merr = 1'b1;
        for (int m = 0; m < j; m++)
          if (retire_en_i[m] && int'(retire_preg_i[m*PW +: PW]) == tag) merr = 1'b1;
      end
    end
`endif
    space = DEPTH - c;
    for (int j = 0; j < RET_W; j++) begin
      if (retire_en_i[j]) begin
        if (space > 0) begin
          mem[mtail % DEPTH] = int'(retire_preg_i[j*PW +: PW]);
          mtail++;
          space--;
        end else begin
          merr = 1'b1;
        end
      end
    end
    if (branch_state_i == PREDICT_WRONG) mhead = rc_abs;
    else                                 mhead = mhead + pops;
  endtask

  always @(negedge clk) begin
    int c;
    if (model_ok && !rst) begin
      c = mtail - mhead;
      chk("free_cnt", int'(free_cnt_o), c);
      chk("cur_head", int'(free_preg_cur_head_o), int'(enc(mhead)));
      chk("fl_err", int'(fl_err_o), int'(merr));
      for (int i = 0; i < DISP_W; i++) begin
        chk($sformatf("vld%0d", i), int'(free_preg_vld_o[i]), (i < c) ? 1 : 0);
        if (i < c) chk($sformatf("tag%0d", i), lane_tag(i), mem[(mhead + i) % DEPTH]);
      end
    end
  end

  task automatic cyc(input logic [1:0] de, input logic [1:0] re, input int t0, input int t1,
                     input logic [`BR_STATE_W-1:0] br, input int rc_abs);
    dispatch_en_i  = de;
    retire_en_i    = re;
    retire_preg_i  = {PW'(t1), PW'(t0)};
    branch_state_i = br;
    rc_head_i      = enc(rc_abs);
    @(posedge clk);
    model_step(rc_abs);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] de, input logic [1:0] re, input logic [`BR_STATE_W-1:0] br);
    dispatch_en_i  = de;
    retire_en_i    = re;
    retire_preg_i  = {PW'(11), PW'(12)};
    branch_state_i = br;
    rc_head_i      = '0;
    rst            = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    rst            = 1'b0;
    dispatch_en_i  = '0;
    retire_en_i    = '0;
    branch_state_i = NO_BRANCH;
  endtask

  initial begin
    rst            = 1'b1;
    dispatch_en_i  = '0;
    retire_en_i    = '0;
    retire_preg_i  = '0;
    branch_state_i = NO_BRANCH;
    rc_head_i      = '0;

    do_reset(2'b00, 2'b00, NO_BRANCH);
    chk("rst_cnt", int'(free_cnt_o), 32);
    chk("rst_lane0", lane_tag(0), 32);
    chk("rst_lane1", lane_tag(1), 33);
    chk("rst_vld", int'(free_preg_vld_o), 3);
    chk("rst_head", int'(free_preg_cur_head_o), 0);
    chk("rst_err", int'(fl_err_o), 0);
    cyc(2'b00, 2'b00, 0, 0, NO_BRANCH, 0);

    // Drain the whole list two tags per cycle
    for (int n = 0; n < 16; n++) begin
      chk("drain_lane0", lane_tag(0), 32 + 2 * n);
      cyc(2'b11, 2'b00, 0, 0, PREDICT_RIGHT, 0);
    end
    chk("empty_cnt", int'(free_cnt_o), 0);
    chk("empty_vld", int'(free_preg_vld_o), 0);
    chk("empty_head", int'(free_preg_cur_head_o), 32);

    cyc(2'b00, 2'b11, 5, 9, NO_BRANCH, 0);
    chk("refill_vld", int'(free_preg_vld_o), 3);
    chk("refill_lane0", lane_tag(0), 5);
    chk("refill_lane1", lane_tag(1), 9);
    chk("refill_cnt", int'(free_cnt_o), 2);

    cyc(2'b11, 2'b00, 0, 0, NO_BRANCH, 0);
    cyc(2'b01, 2'b00, 0, 0, NO_BRANCH, 0);
    chk("empty_pop_err", int'(fl_err_o), 1);

    // Reset with traffic and a mispredict present must still win
    do_reset(2'b11, 2'b11, PREDICT_WRONG);
    chk("midrst_cnt", int'(free_cnt_o), 32);
    chk("midrst_err", int'(fl_err_o), 0);
    chk("midrst_head", int'(free_preg_cur_head_o), 0);

    cyc(2'b11, 2'b00, 0, 0, NO_BRANCH, 0);
    cyc(2'b11, 2'b00, 0, 0, NO_BRANCH, 0);
    chk("ckpt_lane0", lane_tag(0), 36);
    for (int n = 0; n < 3; n++) cyc(2'b11, 2'b00, 0, 0, NO_BRANCH, 0);
    cyc(2'b11, 2'b01, 7, 0, PREDICT_WRONG, 4);
    chk("recov_head", int'(free_preg_cur_head_o), 4);
    chk("recov_cnt", int'(free_cnt_o), 29);
    chk("recov_lane0", lane_tag(0), 36);
    chk("recov_err", int'(fl_err_o), 0);

    cyc(2'b10, 2'b00, 0, 0, NO_BRANCH, 0);
    chk("nonprefix_err", int'(fl_err_o), 1);
    chk("nonprefix_cnt", int'(free_cnt_o), 29);

    do_reset(2'b00, 2'b00, NO_BRANCH);
    cyc(2'b00, 2'b01, 3, 0, NO_BRANCH, 0);
    chk("full_cnt", int'(free_cnt_o), 32);
    chk("full_err", int'(fl_err_o), 1);

    do_reset(2'b00, 2'b00, NO_BRANCH);
    cyc(2'b11, 2'b00, 0, 0, NO_BRANCH, 0);
    cyc(2'b11, 2'b11, 32, 33, NO_BRANCH, 0);
    chk("popush_cnt", int'(free_cnt_o), 30);
    cyc(2'b00, 2'b10, 0, 2, NO_BRANCH, 0);
    chk("lane1_only_cnt", int'(free_cnt_o), 31);
    chk("pre_dup_err", int'(fl_err_o), 0);
    cyc(2'b00, 2'b01, 40, 0, NO_BRANCH, 0);
    chk("dup_cnt", int'(free_cnt_o), 32);
`ifdef FL_DUP_CHECK_EN
    chk("dup_err", int'(fl_err_o), 1);
`else
    chk("dup_err", int'(fl_err_o), 0);
`endif
    cyc(2'b00, 2'b00, 0, 0, NO_BRANCH, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/free_list_nway.md
Name: free_list_nway

Overview:
- Parametrised N-wide successor to the single-ported physical-register free list.
- Circular FIFO of free physical register tags.
- Supplies up to DISP_W new destination tags per cycle to dispatch and map table, and accepts up to RET_W freed tags per cycle from ROB retire.
- Supports single-cycle head restore from the branch stack checkpoint on mispredict.

Parameters:
- PREG_NUM, 64, total physical registers.
- AREG_NUM, 32, architectural registers; tags 0..AREG_NUM-1 are mapped at reset.
- DISP_W, 2, dispatch (pop) lanes per cycle.
- RET_W, 2, retire (push) lanes per cycle.
- Derived localparams:
  - DEPTH = PREG_NUM-AREG_NUM.
  - PW = $clog2(PREG_NUM), tag width.
  - QW = $clog2(DEPTH)+1, pointer width including wrap bit.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- dispatch_en_i  in  DISP_W  per-lane pop request; must be a contiguous prefix from lane 0.
- retire_en_i  in  RET_W  per-lane push valid; any pattern allowed.
- retire_preg_i  in  RET_W*PW  freed tag per lane.
- branch_state_i  in  `BR_STATE_W  branch outcome from ROB (NO_BRANCH / PREDICT_RIGHT / PREDICT_WRONG).
- rc_head_i  in  QW  checkpointed head, wrap bit included, from branch stack.
- free_preg_vld_o  out  DISP_W  lane i tag valid (i < count).
- free_preg_o  out  DISP_W*PW  tag offered on lane i = entry[head+i].
- free_preg_cur_head_o  out  QW  current head, for checkpointing.
- free_cnt_o  out  QW  number of free entries.
- fl_err_o  out  1  sticky error flag.

Behaviour:
- Storage: DEPTH-entry array; head and tail are QW-bit pointers. Index = ptr mod DEPTH; the wrap bit toggles when the index passes DEPTH-1. DEPTH need not be a power of two, so wrap is explicit compare-and-reset, not a bit slice.
- count = tail-head, in QW-bit arithmetic with wrap handling. Empty when count==0. Full when count==DEPTH.
- Reset (sync, rst=1 at posedge):
  - entry[k]=AREG_NUM+k.
  - head=0, tail=DEPTH with wrap bit=1 and index=0.
  - free_cnt_o=DEPTH, fl_err_o=0.
  - free_preg_vld_o all-ones when DEPTH>=DISP_W.
  - All other outputs follow combinationally from this state.
- Outputs are combinational from registered head/tail/array, so there is zero-cycle read latency. Pop and push take effect at the next edge.
- Pop:
  - pops = number of lanes i with dispatch_en_i[i] & free_preg_vld_o[i]. Lanes without vld are ignored and set fl_err_o.
  - A non-prefix dispatch_en_i also sets fl_err_o; only the prefix is honoured.
  - head += pops.
- Push:
  - Enabled lanes are compacted in lane order and written at tail, tail+1, ...
  - tail += number of pushes.
  - A push that would make count exceed DEPTH is dropped, and fl_err_o is set.
- Simultaneous pop and push: both apply. Push space is computed from the pre-pop count, so nothing is bypassed. A retired tag becomes poppable the next cycle.
- Empty: all vld are 0 and pops are 0. A push in the same cycle makes vld[0]=1 next cycle.
- PREDICT_WRONG:
  - head <= rc_head_i.
  - Same-cycle pops are discarded.
  - Same-cycle pushes still apply, because retire is older than the branch.
  - Next count = tail_next - rc_head_i.
- PREDICT_RIGHT / NO_BRANCH: normal operation.
- Reset mid-operation overrides everything, including recovery and push.
- fl_err_o is cleared only by rst.

Optional Feature:
- FL_DUP_CHECK_EN: adds a PREG_NUM-bit in-list scoreboard.
  - Reset: bits AREG_NUM..PREG_NUM-1 set.
  - Push sets the bit; pop clears it.
  - A push of a tag whose bit is already set, or two lanes pushing the same tag in one cycle, sets fl_err_o. The push still proceeds.
  - Recovery: bits for entries between rc_head_i and old head are re-set. This is computed iteratively over DEPTH.
- Without the macro: no scoreboard; fl_err_o reflects only the overflow and illegal-pop errors.

Decomposition:
- Shared package (existing sys_defs header): `BR_STATE_W and the NO_BRANCH / PREDICT_RIGHT / PREDICT_WRONG encodings. Add typedef preg_t (PW bits) and constants PREG_NUM and AREG_NUM.
- One sub-module: fl_ptr_add.
  - Combinational wrap-aware adder: QW-bit pointer plus a 0..max(DISP_W,RET_W) increment, producing the wrapped pointer.
  - Instantiated for head_next, tail_next and each lane's read/write index.

Test Plan:
- Reset, then idle: free_cnt_o=32, free_preg_o lane0=32, lane1=33, vld=2'b11, head=0.
- Dispatch 2'b11 for 16 cycles: tags 32..63 issued in order. Afterwards count=0, vld=2'b00, head index=0 with wrap bit=1.
- At empty, retire tags 5 and 9 on both lanes: next cycle vld=2'b11, lane0=5, lane1=9, count=2.
- Checkpoint head=4 (rc_head_i=4). Dispatch 6 more tags, then PREDICT_WRONG with rc_head_i=4 plus dispatch 2'b11 and retire of 1 tag in the same cycle. Required: head=4, pops ignored, count=DEPTH-4+1-(retires already done); the lane0 tag equals the one issued at head 4.
- With the list full (count=32), retire 1 tag: push dropped, count stays 32, fl_err_o=1.
- FL_DUP_CHECK_EN build: retire tag 40 while 40 is still in the list -> fl_err_o=1. Without the macro, fl_err_o stays 0.
